// File: rtl/kf76489_pkg.sv
// Shared types and byte-decode helpers for the KF76489 host bus interface.
package kf76489_pkg;

  typedef enum logic [1:0] {
    TONE0 = 2'd0,
    TONE1 = 2'd1,
    TONE2 = 2'd2,
    NOISE = 2'd3
  } channel_t;

  typedef struct packed {
    channel_t channel;
    logic     attenuation_select;
  } latch_register_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    BUSY   = 2'd2
  } state_t;

  // Bit positions in the host byte (bit k = datasheet Dk).
  localparam int unsigned LATCH_FLAG_BIT  = 0;
  localparam int unsigned CHANNEL_MSB_BIT = 1;
  localparam int unsigned CHANNEL_LSB_BIT = 2;
  localparam int unsigned ATTENUATION_BIT = 3;

  // Extract the latch target carried by a latch byte.
  function automatic latch_register_t decode_latch(input logic [7:0] byte_in);
    latch_register_t result;
    result.channel            = channel_t'({byte_in[CHANNEL_MSB_BIT], byte_in[CHANNEL_LSB_BIT]});
    result.attenuation_select = byte_in[ATTENUATION_BIT];
    return result;
  endfunction

endpackage

// File: rtl/kf76489_input_synchronizer.sv
// Two-flop synchronizer for an active-low asynchronous host pin; resets to the inactive level.
module kf76489_input_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic stage1;

  // Double-register the pin into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage1   <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      stage1   <= async_in;
      sync_out <= stage1;
    end
  end

endmodule

// File: rtl/kf76489_bus_interface.sv
// KF76489 host write port: synchronizes host pins, decodes latch/data bytes,
// issues single-clock write strobes and drives the READY handshake.
module kf76489_bus_interface #(
  parameter int unsigned BUSY_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_enable,
  input  logic       chip_enable_n,
  input  logic       write_enable_n,
  input  logic [7:0] data_bus_in,
  output logic       ready,
  output logic [7:0] internal_data_bus,
  output logic [2:0] write_tone_frequency_low,
  output logic [2:0] write_tone_frequency_high,
  output logic [2:0] write_tone_attenuation,
  output logic       write_noise_control,
  output logic       write_noise_attenuation
);

  import kf76489_pkg::*;

  localparam int unsigned COUNT_WIDTH = $clog2(BUSY_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(BUSY_CYCLES - 1);

  logic                   chip_enable_sync_n;
  logic                   write_enable_sync_n;
  logic                   access;
  logic                   armed;
  logic [1:0]             settle;
  logic                   accept;
  state_t                 state;
  state_t                 next_state;
  logic [COUNT_WIDTH-1:0] busy_count;
  latch_register_t        latch_register;
  latch_register_t        target;
  logic [2:0]             tone_mask;
  logic [2:0]             next_frequency_low;
  logic [2:0]             next_frequency_high;
  logic [2:0]             next_attenuation;
  logic                   next_noise_control;
  logic                   next_noise_attenuation;

  kf76489_input_synchronizer chip_enable_synchronizer (
    .clock    (clock),
    .reset    (reset),
    .async_in (chip_enable_n),
    .sync_out (chip_enable_sync_n)
  );

  kf76489_input_synchronizer write_enable_synchronizer (
    .clock    (clock),
    .reset    (reset),
    .async_in (write_enable_n),
    .sync_out (write_enable_sync_n)
  );

  assign access = ~chip_enable_sync_n & ~write_enable_sync_n;
  assign accept = (state == IDLE) & access & armed;

  // Re-arm once the host has been seen idle. The synchronizers read "idle" for
  // two clocks after reset regardless of the pins, so arming waits for them to
  // settle; otherwise an access held through reset would be accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[0], 1'b1};
      if (accept) begin
        armed <= 1'b0;
      end else if (settle[1] && !access) begin
        armed <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state and READY.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) next_state = STROBE;
      end
      STROBE: next_state = BUSY;
      BUSY: begin
        if (clock_enable && (busy_count == LAST_COUNT)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Busy counter: cleared in STROBE so BUSY starts at zero, counts clock_enable ticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_count <= '0;
    end else if (state == STROBE) begin
      busy_count <= '0;
    end else if ((state == BUSY) && clock_enable) begin
      busy_count <= busy_count + 1'b1;
    end
  end

  // Decode the strobe a byte would produce against the current latch register.
  always_comb begin
    target                 = latch_register;
    next_frequency_low     = '0;
    next_frequency_high    = '0;
    next_attenuation       = '0;
    next_noise_control     = 1'b0;
    next_noise_attenuation = 1'b0;
    if (data_bus_in[LATCH_FLAG_BIT]) target = decode_latch(data_bus_in);
    tone_mask = 3'b001 << target.channel;
    if (target.channel == NOISE) begin
      if (target.attenuation_select) next_noise_attenuation = 1'b1;
      else                           next_noise_control     = 1'b1;
    end else if (target.attenuation_select) begin
      next_attenuation = tone_mask;
    end else if (data_bus_in[LATCH_FLAG_BIT]) begin
      next_frequency_low = tone_mask;
    end else begin
      next_frequency_high = tone_mask;
    end
  end

  // Register the accepted byte, latch target and one-clock strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      internal_data_bus         <= '0;
      latch_register            <= '{channel: TONE0, attenuation_select: 1'b0};
      write_tone_frequency_low  <= '0;
      write_tone_frequency_high <= '0;
      write_tone_attenuation    <= '0;
      write_noise_control       <= 1'b0;
      write_noise_attenuation   <= 1'b0;
    end else begin
      write_tone_frequency_low  <= '0;
      write_tone_frequency_high <= '0;
      write_tone_attenuation    <= '0;
      write_noise_control       <= 1'b0;
      write_noise_attenuation   <= 1'b0;
      if (accept) begin
        internal_data_bus         <= data_bus_in;
        write_tone_frequency_low  <= next_frequency_low;
        write_tone_frequency_high <= next_frequency_high;
        write_tone_attenuation    <= next_attenuation;
        write_noise_control       <= next_noise_control;
        write_noise_attenuation   <= next_noise_attenuation;
        if (data_bus_in[LATCH_FLAG_BIT]) latch_register <= target;
      end
    end
  end

endmodule
